// File: rtl/deadlock_origin_reporter.sv
// deadlock_origin_reporter: debounces per-process deadlock flags, picks one
// origin, reports it to the monitor, then clears tokens and waits for drain.
// Optional macro DL_REPORT_EVENT_CNT_EN adds the dl_event_cnt output.
module deadlock_origin_reporter #(
  parameter int PROC_NUM       = 2,
  parameter int CONFIRM_CYCLES = 2,
  parameter int ID_W           = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_in_vec,
  output logic                dl_detect_out,
  output logic [PROC_NUM-1:0] origin,
  output logic                token_clear,
  output logic                report_vld,
  output logic [ID_W-1:0]     report_id,
  input  logic                report_rdy
`ifdef DL_REPORT_EVENT_CNT_EN
  ,
  output logic [15:0]         dl_event_cnt
`endif
);

  localparam int CW = (CONFIRM_CYCLES > 1) ? $clog2(CONFIRM_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CONFIRM_CYCLES - 1);
  localparam logic [PROC_NUM-1:0] ONE = PROC_NUM'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONF,
    S_DET,
    S_CLR,
    S_DRN
  } state_t;

  state_t              r_state;
  logic [ID_W-1:0]     r_cand;
  logic [CW-1:0]       r_cnt;
  logic                r_det;
  logic [PROC_NUM-1:0] r_origin;
  logic                r_tclr;
  logic                r_vld;
  logic [ID_W-1:0]     r_id;

  logic [ID_W-1:0]     w_pick;
  logic                w_cand_set;
  logic [PROC_NUM-1:0] w_onehot;
  logic                w_handshake;

  // Fixed-priority encoder: lowest set flag wins.
  always_comb begin
    w_pick = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (dl_in_vec[i]) w_pick = ID_W'(i);
    end
  end

  assign w_cand_set  = dl_in_vec[r_cand];
  assign w_onehot    = ONE << r_cand;
  assign w_handshake = (r_state == S_DET) && r_vld && report_rdy;

  // Detection FSM with all outputs registered alongside the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cand   <= '0;
      r_cnt    <= '0;
      r_det    <= 1'b0;
      r_origin <= '0;
      r_tclr   <= 1'b0;
      r_vld    <= 1'b0;
      r_id     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (|dl_in_vec) begin
            r_cand  <= w_pick;
            r_cnt   <= '0;
            r_state <= S_CONF;
          end
        end
        S_CONF: begin
          if (!w_cand_set) begin
            r_state <= S_IDLE;
          end else if (r_cnt == LAST) begin
            r_state  <= S_DET;
            r_det    <= 1'b1;
            r_origin <= w_onehot;
            r_vld    <= 1'b1;
            r_id     <= r_cand;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DET: begin
          if (w_handshake) begin
            r_state <= S_CLR;
            r_vld   <= 1'b0;
            r_id    <= '0;
            r_tclr  <= 1'b1;
          end
        end
        S_CLR: begin
          r_state  <= S_DRN;
          r_tclr   <= 1'b0;
          r_origin <= '0;
        end
        S_DRN: begin
          if (dl_in_vec == '0) begin
            r_state <= S_IDLE;
            r_det   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign dl_detect_out = r_det;
  assign origin        = r_origin;
  assign token_clear   = r_tclr;
  assign report_vld    = r_vld;
  assign report_id     = r_id;

`ifdef DL_REPORT_EVENT_CNT_EN
  logic [15:0] r_evt;

  // Saturating count of completed report handshakes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_evt <= '0;
    end else if (w_handshake && (r_evt != 16'hFFFF)) begin
      r_evt <= r_evt + 16'd1;
    end
  end

  assign dl_event_cnt = r_evt;
`endif

endmodule
